// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and its sequencing controller (slave).
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             halt_id;
    logic             use_rs_id;
    logic             use_rd_id;
    logic [2:0]       rs_id;
    logic [2:0]       rd_id;
    logic             load_ex;
    logic [2:0]       rd_ex;
    logic             branch_taken_ex;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_mem_write;
    logic             mem_wb_write;
    logic             running;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output start, halt_id, use_rs_id, use_rd_id, rs_id, rd_id,
               load_ex, rd_ex, branch_taken_ex,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
               ex_mem_write, mem_wb_write, running, stall_count, flush_count
    );

    modport slave (
        input  start, halt_id, use_rs_id, use_rd_id, rs_id, rd_id,
               load_ex, rd_ex, branch_taken_ex,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble,
               ex_mem_write, mem_wb_write, running, stall_count, flush_count
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: load-use stalls, branch flushes, halt/drain/restart
// and saturating stall/flush event counters.
module pipe_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic      clock,
    input  logic      reset,
    pipe_ctrl_if.slave bus
);
    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic hz;
    logic pc_w, ifid_w, ifid_fl, idex_bub, exmem_w, memwb_w, run_o;
    logic stall_inc, flush_inc;

    assign hz = bus.load_ex & ((bus.use_rs_id & (bus.rs_id == bus.rd_ex)) |
                               (bus.use_rd_id & (bus.rd_id == bus.rd_ex)));

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        pc_w      = 1'b0;
        ifid_w    = 1'b0;
        ifid_fl   = 1'b0;
        idex_bub  = 1'b0;
        exmem_w   = 1'b0;
        memwb_w   = 1'b0;
        run_o     = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            S_RUN, S_DRAIN: begin
                run_o = 1'b1;
                if (bus.branch_taken_ex) begin
                    // Wrong-path HALT or hazard is discarded by the flush.
                    pc_w      = 1'b1;
                    ifid_w    = 1'b1;
                    ifid_fl   = 1'b1;
                    idex_bub  = 1'b1;
                    exmem_w   = 1'b1;
                    memwb_w   = 1'b1;
                    flush_inc = 1'b1;
                    state_d   = S_RUN;
                end else if (state_q == S_DRAIN || hz || bus.halt_id) begin
                    idex_bub = 1'b1;
                    exmem_w  = 1'b1;
                    memwb_w  = 1'b1;
                    if (state_q == S_DRAIN) begin
                        if (dcnt_q == '0) state_d = S_HALTED;
                        else              dcnt_d  = dcnt_q - DW'(1);
                    end else if (hz) begin
                        stall_inc = 1'b1;
                    end else begin
                        dcnt_d  = DW'(DRAIN_CYCLES - 1);
                        state_d = S_DRAIN;
                    end
                end else begin
                    pc_w    = 1'b1;
                    ifid_w  = 1'b1;
                    exmem_w = 1'b1;
                    memwb_w = 1'b1;
                end
            end
            S_HALTED: begin
                if (bus.start) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_inc && stall_q != '1) stall_d = stall_q + CNT_W'(1);
        if (flush_inc && flush_q != '1) flush_d = flush_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_RUN;
            dcnt_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    // Reset forces every control output low in the same cycle.
    assign bus.pc_write     = reset & pc_w;
    assign bus.if_id_write  = reset & ifid_w;
    assign bus.if_id_flush  = reset & ifid_fl;
    assign bus.id_ex_bubble = reset & idex_bub;
    assign bus.ex_mem_write = reset & exmem_w;
    assign bus.mem_wb_write = reset & memwb_w;
    assign bus.running      = reset & run_o;
    assign bus.stall_count  = stall_q;
    assign bus.flush_count  = flush_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and randomized check of pipe_ctrl against a cycle-level behavioural model.
module tb_pipe_ctrl;
    localparam int unsigned DRAIN = 3;
    localparam int unsigned CW    = 16;
    localparam int unsigned CMAX  = (1 << CW) - 1;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    pipe_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Model: halted flag plus number of drain cycles still owed (0 = not draining).
    bit m_halted  = 1'b0;
    int m_drain   = 0;
    int m_stall   = 0;
    int m_flush   = 0;
    bit m_known   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit st, input bit hlt, input bit urs, input bit urd,
                          input int rs, input int rd, input bit ld, input int rdx, input bit br);
        bus.start           = st;
        bus.halt_id         = hlt;
        bus.use_rs_id       = urs;
        bus.use_rd_id       = urd;
        bus.rs_id           = 3'(rs);
        bus.rd_id           = 3'(rd);
        bus.load_ex         = ld;
        bus.rd_ex           = 3'(rdx);
        bus.branch_taken_ex = br;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Check the combinational outputs for the current inputs, then advance one clock.
    task automatic step();
        bit hz, draining;
        bit [6:0] e;  // pc, ifid_w, ifid_fl, bubble, exmem, memwb, running
        #1;
        hz = bus.load_ex && ((bus.use_rs_id && bus.rs_id == bus.rd_ex) ||
                             (bus.use_rd_id && bus.rd_id == bus.rd_ex));
        draining = (m_drain > 0);
        if (!reset)                   e = 7'b000_0000;
        else if (m_halted)            e = 7'b000_0000;
        else if (bus.branch_taken_ex) e = 7'b111_1111;
        else if (draining || hz || bus.halt_id) e = 7'b000_1111;
        else                          e = 7'b110_0111;
        chk("pc_write",     bus.pc_write,     e[6]);
        chk("if_id_write",  bus.if_id_write,  e[5]);
        chk("if_id_flush",  bus.if_id_flush,  e[4]);
        chk("id_ex_bubble", bus.id_ex_bubble, e[3]);
        chk("ex_mem_write", bus.ex_mem_write, e[2]);
        chk("mem_wb_write", bus.mem_wb_write, e[1]);
        chk("running",      bus.running,      e[0]);
        if (m_known) begin
            chk("stall_count", bus.stall_count, m_stall);
            chk("flush_count", bus.flush_count, m_flush);
        end
        @(posedge clock);
        if (!reset) begin
            m_halted = 1'b0; m_drain = 0; m_stall = 0; m_flush = 0; m_known = 1'b1;
        end else if (m_halted) begin
            if (bus.start) m_halted = 1'b0;
        end else if (bus.branch_taken_ex) begin
            if (m_flush < CMAX) m_flush++;
            m_drain = 0;
        end else if (draining) begin
            m_drain--;
            if (m_drain == 0) m_halted = 1'b1;
        end else if (hz) begin
            if (m_stall < CMAX) m_stall++;
        end else if (bus.halt_id) begin
            m_drain = DRAIN;
        end
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        step(); step();
        reset = 1'b1;

        step();
        chk("rst_pc_write", bus.pc_write, 1);
        chk("rst_running", bus.running, 1);
        chk("rst_stall", bus.stall_count, 0);
        chk("rst_flush", bus.flush_count, 0);

        // branch together with a live hazard counts only as a flush
        set_in(0, 0, 1, 0, 3, 0, 1, 3, 1); step();
        chk("brhz_flush", bus.flush_count, 1);
        chk("brhz_stall", bus.stall_count, 0);

        // load-use stall, then the same without the register read
        set_in(0, 0, 1, 0, 3, 0, 1, 3, 0); step();
        chk("lu_stall", bus.stall_count, 1);
        set_in(0, 0, 0, 0, 3, 0, 1, 3, 0); step();
        chk("lu_nostall", bus.stall_count, 1);
        set_in(0, 0, 0, 1, 0, 5, 1, 5, 0); step();
        set_in(0, 0, 1, 1, 2, 5, 1, 6, 0); step();
        chk("lu_rd_path", bus.stall_count, 2);

        // halt, drain, halted, restart
        idle(); bus.halt_id = 1'b1; step();
        idle();
        for (int i = 0; i < int'(DRAIN); i++) begin
            #1 chk("drain_memwb", bus.mem_wb_write, 1);
            step();
        end
        #1 chk("halted_running", bus.running, 0);
        chk("halted_memwb", bus.mem_wb_write, 0);
        step(); step();
        bus.start = 1'b1; step();
        bus.start = 1'b0;
        #1 chk("restart_pc", bus.pc_write, 1);
        step();
        bus.start = 1'b1; step(); step();
        idle();

        // wrong-path halt cancelled by a branch
        bus.halt_id = 1'b1; step();
        idle(); bus.branch_taken_ex = 1'b1; step();
        idle();
        for (int i = 0; i < 5; i++) step();
        #1 chk("wrongpath_running", bus.running, 1);
        chk("wrongpath_flush", bus.flush_count, 2);

        // reset in the middle of a drain
        bus.halt_id = 1'b1; step();
        idle(); step();
        reset = 1'b0; step();
        reset = 1'b1;
        #1 chk("midrst_running", bus.running, 1);
        chk("midrst_stall", bus.stall_count, 0);
        chk("midrst_flush", bus.flush_count, 0);
        step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)),
                   $urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 299) != 0);
            step();
        end

        // stall counter saturation
        reset = 1'b0; idle(); step();
        reset = 1'b1;
        set_in(0, 0, 1, 0, 4, 0, 1, 4, 0);
        for (int i = 0; i < 65540; i++) step();
        chk("sat_stall", bus.stall_count, 16'hFFFF);
        idle(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
